// File: rtl/gat_dbg_pkg.sv
// gat_dbg_pkg: readout index map shared by the GAT stage monitor and its debug wrapper.
package gat_dbg_pkg;
    localparam int IDX_ID      = 0;
    localparam int IDX_STICKY  = 1;
    localparam int IDX_CYCLE   = 2;
    localparam int IDX_TSV     = 3;
    localparam int IDX_TS_BASE = 4;

    function automatic int idx_cnt_base(input int n);
        return IDX_TS_BASE + n;
    endfunction

    function automatic int idx_cap_base(input int n);
        return IDX_TS_BASE + 2 * n;
    endfunction
endpackage

// File: rtl/dbg_stage_probe.sv
// dbg_stage_probe: per-stage sticky valid/ready flags, first-valid timestamp and saturating beat count.
module dbg_stage_probe #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             vld,
    input  logic             rdy,
    input  logic [CNT_W-1:0] cycle,
    output logic             vld_sticky,
    output logic             rdy_sticky,
    output logic             ts_valid,
    output logic [CNT_W-1:0] first_ts,
    output logic [CNT_W-1:0] vld_cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sticky <= 1'b0;
            rdy_sticky <= 1'b0;
            ts_valid   <= 1'b0;
            first_ts   <= '0;
            vld_cnt    <= '0;
        end else begin
            // A set event in the clear cycle survives the clear.
            vld_sticky <= vld | (vld_sticky & ~clear_i);
            rdy_sticky <= rdy | (rdy_sticky & ~clear_i);
            ts_valid   <= vld | (ts_valid & ~clear_i);
            if (vld && (clear_i || !ts_valid))
                first_ts <= cycle;
            else if (clear_i)
                first_ts <= '0;
            if (clear_i)
                vld_cnt <= CNT_W'(vld);
            else if (vld && vld_cnt != '1)
                vld_cnt <= vld_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/gat_stage_monitor.sv
// gat_stage_monitor: debug monitor for GAT pipeline stages with address-matched capture
// slots and a registered, indexed 32-bit readout port.
module gat_stage_monitor
    import gat_dbg_pkg::*;
#(
    parameter int          NUM_STAGES = 4,
    parameter int          NUM_CAP    = 2,
    parameter int          ADDR_W     = 16,
    parameter int          CAP_W      = 32,
    parameter int          CNT_W      = 32,
    parameter logic [31:0] MON_ID     = 32'h00F4_0104
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    input  logic [NUM_STAGES-1:0]     stage_vld_i,
    input  logic [NUM_STAGES-1:0]     stage_rdy_i,
    input  logic                      cap_en_i,
    input  logic [ADDR_W-1:0]         cap_addr_i,
    input  logic [CAP_W-1:0]          cap_data_i,
    input  logic [NUM_CAP*ADDR_W-1:0] cap_match_i,
    input  logic [NUM_CAP-1:0]        cap_mode_i,
    input  logic [7:0]                rd_sel_i,
    output logic [31:0]               rd_data_o,
    output logic [2*NUM_STAGES-1:0]   sticky_o
);
    localparam int CNT_IDX = idx_cnt_base(NUM_STAGES);
    localparam int CAP_IDX = idx_cap_base(NUM_STAGES);
    localparam int CV_IDX  = CAP_IDX + NUM_CAP;

    logic [CNT_W-1:0]      cyc;
    logic [NUM_STAGES-1:0] vld_sticky, rdy_sticky, ts_valid;
    logic [CNT_W-1:0]      first_ts [NUM_STAGES];
    logic [CNT_W-1:0]      vld_cnt  [NUM_STAGES];
    logic [NUM_CAP-1:0]    hit, cap_valid;
    logic [CAP_W-1:0]      cap_data [NUM_CAP];
    logic [31:0]           rd_next;
    int                    sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cyc <= '0;
        else if (cyc != '1)
            cyc <= cyc + CNT_W'(1);
    end

    genvar s;
    generate
        for (s = 0; s < NUM_STAGES; s++) begin : g_probe
            dbg_stage_probe #(.CNT_W(CNT_W)) u_probe (
                .clk        (clk),
                .rst_n      (rst_n),
                .clear_i    (clear_i),
                .vld        (stage_vld_i[s]),
                .rdy        (stage_rdy_i[s]),
                .cycle      (cyc),
                .vld_sticky (vld_sticky[s]),
                .rdy_sticky (rdy_sticky[s]),
                .ts_valid   (ts_valid[s]),
                .first_ts   (first_ts[s]),
                .vld_cnt    (vld_cnt[s])
            );
        end
    endgenerate

    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_CAP; k++)
            hit[k] = cap_en_i && cap_addr_i == cap_match_i[k*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid <= '0;
            for (int k = 0; k < NUM_CAP; k++)
                cap_data[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CAP; k++) begin
                // First-match slots only lock once valid; a clear reopens them this cycle.
                if (hit[k] && (clear_i || !cap_mode_i[k] || !cap_valid[k])) begin
                    cap_data[k]  <= cap_data_i;
                    cap_valid[k] <= 1'b1;
                end else if (clear_i) begin
                    cap_data[k]  <= '0;
                    cap_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign sel = {24'd0, rd_sel_i};

    always_comb begin
        rd_next = '0;
        if (sel == IDX_ID)     rd_next = MON_ID;
        if (sel == IDX_STICKY) rd_next = 32'({vld_sticky, rdy_sticky});
        if (sel == IDX_CYCLE)  rd_next = 32'(cyc);
        if (sel == IDX_TSV)    rd_next = 32'(ts_valid);
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (sel == IDX_TS_BASE + i) rd_next = 32'(first_ts[i]);
            if (sel == CNT_IDX + i)     rd_next = 32'(vld_cnt[i]);
        end
        for (int k = 0; k < NUM_CAP; k++)
            if (sel == CAP_IDX + k) rd_next = 32'(cap_data[k]);
        if (sel == CV_IDX)     rd_next = 32'(cap_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data_o <= '0;
        else
            rd_data_o <= rd_next;
    end

    assign sticky_o = {vld_sticky, rdy_sticky};
endmodule

// File: tb/tb_gat_stage_monitor.sv
// tb_gat_stage_monitor: directed readout-table bench for gat_stage_monitor, with a CNT_W=4
// instance sharing the stimulus for the saturation cases.
module tb_gat_stage_monitor;
    localparam logic [31:0] ID = 32'h00F4_0104;

    logic        clk = 1'b0, rst_n = 1'b1, clear_i = 1'b0, cap_en_i = 1'b0;
    logic [3:0]  stage_vld_i = '0, stage_rdy_i = '0;
    logic [15:0] cap_addr_i = '0;
    logic [31:0] cap_data_i = '0, cap_match_i = '0;
    logic [1:0]  cap_mode_i = '0;
    logic [7:0]  rd_sel_i = '0;
    logic [31:0] rd_data_o, rd_data_sat;
    logic [7:0]  sticky_o, sticky_sat;

    int errors = 0, checks = 0, edges, t_clr;

    typedef struct {
        logic [7:0]  sel;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    gat_stage_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
        .stage_vld_i(stage_vld_i), .stage_rdy_i(stage_rdy_i),
        .cap_en_i(cap_en_i), .cap_addr_i(cap_addr_i), .cap_data_i(cap_data_i),
        .cap_match_i(cap_match_i), .cap_mode_i(cap_mode_i),
        .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o), .sticky_o(sticky_o)
    );

    gat_stage_monitor #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i),
        .stage_vld_i(stage_vld_i), .stage_rdy_i(stage_rdy_i),
        .cap_en_i(cap_en_i), .cap_addr_i(cap_addr_i), .cap_data_i(cap_data_i),
        .cap_match_i(cap_match_i), .cap_mode_i(cap_mode_i),
        .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_sat), .sticky_o(sticky_sat)
    );

    always #5 clk = ~clk;

    // Counter value the DUT will sample at the next rising edge.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] sel, input logic [31:0] exp);
        rd_sel_i = sel;
        tick;
        chk($sformatf("rd[%0d]", sel), rd_data_o, exp);
    endtask

    task automatic run_vecs;
        foreach (vecs[i]) rd(vecs[i].sel, vecs[i].exp);
        vecs.delete();
    endtask

    task automatic hit(input logic [15:0] a, input logic [31:0] d);
        cap_en_i = 1'b1; cap_addr_i = a; cap_data_i = d;
        tick;
        cap_en_i = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rd", rd_data_o, 32'h0);
        chk("reset_sticky", 32'(sticky_o), 32'h0);
        rst_n = 1'b1;
        rd(0, ID);
        rd(1, 0);

        while (edges < 10) tick;
        stage_vld_i[2] = 1'b1; tick; stage_vld_i[2] = 1'b0;
        while (edges < 15) tick;
        stage_vld_i[2] = 1'b1; tick; tick; stage_vld_i[2] = 1'b0;
        stage_rdy_i[3] = 1'b1; tick; stage_rdy_i[3] = 1'b0;

        cap_match_i = {16'd20, 16'd10};
        cap_mode_i  = 2'b10;
        hit(10, 32'hA); hit(10, 32'hB); hit(20, 32'hC); hit(20, 32'hD);
        chk("sticky_run", 32'(sticky_o), 32'h48);
        vecs = '{'{8'd6, 32'd10}, '{8'd10, 32'd3}, '{8'd1, 32'h48}, '{8'd3, 32'h4},
                 '{8'd4, 32'd0}, '{8'd8, 32'd0}, '{8'd12, 32'hB}, '{8'd13, 32'hC},
                 '{8'd14, 32'h3}, '{8'd15, 32'd0}, '{8'd200, 32'd0}};
        run_vecs();

        cap_mode_i = 2'b01;
        tick;
        hit(10, 32'hE); hit(20, 32'hF);
        rd(12, 32'hB);
        rd(13, 32'hF);

        t_clr = edges;
        clear_i = 1'b1; stage_vld_i[0] = 1'b1;
        cap_en_i = 1'b1; cap_addr_i = 16'd20; cap_data_i = 32'h55;
        tick;
        clear_i = 1'b0; stage_vld_i[0] = 1'b0; cap_en_i = 1'b0;
        chk("sticky_clr", 32'(sticky_o), 32'h10);
        vecs = '{'{8'd1, 32'h10}, '{8'd4, 32'(t_clr)}, '{8'd8, 32'd1}, '{8'd6, 32'd0},
                 '{8'd10, 32'd0}, '{8'd3, 32'h1}, '{8'd12, 32'd0}, '{8'd13, 32'h55},
                 '{8'd14, 32'h2}};
        run_vecs();

        stage_vld_i[1] = 1'b1;
        repeat (20) tick;
        stage_vld_i[1] = 1'b0;
        rd_sel_i = 8'd9; tick;
        chk("cnt1_main", rd_data_o, 32'd20);
        chk("cnt1_sat", rd_data_sat, 32'd15);
        rd_sel_i = 8'd2; tick;
        chk("cycle_sat", rd_data_sat, 32'd15);
        rd_sel_i = 8'd5; tick;
        chk("ts1_sat", rd_data_sat, 32'd15);

        cap_en_i = 1'b1; cap_addr_i = 16'd10; cap_data_i = 32'h77;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rd", rd_data_o, 32'h0);
        chk("async_sticky", 32'(sticky_o), 32'h0);
        chk("async_sat", rd_data_sat, 32'h0);
        cap_en_i = 1'b0;
        repeat (2) @(negedge clk);
        rd_sel_i = 8'd14;
        rst_n = 1'b1;
        tick;
        chk("post_rst_cv", rd_data_o, 32'h0);
        rd(0, ID);
        rd(12, 0);
        rd(1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gat_stage_monitor.md
Name: gat_stage_monitor

Overview:
- Parametrised, register-readable debug monitor for the GAT pipeline stages (SPMM, DMVM, softmax, aggregation, and any added later).
- Per stage: records sticky valid/ready flags, the first-valid timestamp and a saturating valid-beat count.
- Provides NUM_CAP address-matched data-capture slots, with last-match or first-match mode.
- All state is readable through one indexed, registered 32-bit readout port for the debug/AXI-lite wrapper.

Parameters:
- NUM_STAGES, 4, number of monitored pipeline stages (1..16).
- NUM_CAP, 2, number of capture slots (1..8).
- ADDR_W, 16, width of the monitored BRAM address.
- CAP_W, 32, width of captured data (≤32, zero-extended on read).
- CNT_W, 32, width of the cycle and beat counters (≤32).
- MON_ID, 32'h00F4_0104, constant returned at readout index 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous clear of flags, counters and captures (the cycle counter keeps running).
- stage_vld_i  in  NUM_STAGES  per-stage valid pulse/level.
- stage_rdy_i  in  NUM_STAGES  per-stage ready pulse/level.
- cap_en_i  in  1  monitored bus strobe.
- cap_addr_i  in  ADDR_W  monitored address.
- cap_data_i  in  CAP_W  monitored data.
- cap_match_i  in  NUM_CAP*ADDR_W  per-slot match address; slot k occupies bits [k*ADDR_W +: ADDR_W].
- cap_mode_i  in  NUM_CAP  per slot: 0 = last match wins, 1 = first match only.
- rd_sel_i  in  8  readout index.
- rd_data_o  out  32  readout data, registered.
- sticky_o  out  2*NUM_STAGES  {vld_sticky, rdy_sticky} for LED/ILA use.

Behaviour:
- Reset (rst_n low, asynchronous): every register is 0, including rd_data_o, sticky_o, the cycle counter, timestamps, beat counts, captures and cap_valid.
- Cycle counter:
  - Increments every clock from reset.
  - Saturates at all-ones and is not wrapped.
  - clear_i does not affect it.
- Sticky flags:
  - vld_sticky[s] sets on any cycle with stage_vld_i[s]=1; rdy_sticky[s] sets on stage_rdy_i[s]=1.
  - Flags are cleared only by reset or clear_i.
  - If clear_i and a set event occur in the same cycle, the set wins: the flag is 1 the next cycle.
- First timestamp:
  - On the first cycle with stage_vld_i[s]=1 after reset/clear, first_ts[s] ← the current cycle counter value and ts_valid[s] ← 1.
  - Later valids do not update it.
  - If the first valid coincides with clear_i, it is recorded.
- Beat count:
  - vld_cnt[s] increments on every cycle stage_vld_i[s]=1 and saturates at all-ones.
  - clear_i on the same cycle as a valid gives vld_cnt[s] = 1.
- Capture slot k (hit = cap_en_i && cap_addr_i == cap_match_i[k]):
  - Mode 0: cap_data[k] ← cap_data_i on every hit; cap_valid[k] ← 1.
  - Mode 1: capture only if cap_valid[k] = 0; later hits are ignored until clear.
  - Several slots may hit in the same cycle; each slot acts independently.
  - clear_i together with a hit gives a fresh capture of this cycle's data, cap_valid = 1.
  - A change of cap_mode_i mid-run takes effect the next cycle; captured data is not cleared.
- Readout:
  - rd_data_o is registered, 1-cycle latency: index presented at edge n, data valid after edge n+1.
  - It reflects state after that edge's updates.
  - Index map (N = NUM_STAGES, C = NUM_CAP):
    - 0: MON_ID.
    - 1: {vld_sticky, rdy_sticky} zero-extended.
    - 2: cycle counter.
    - 3: ts_valid bits.
    - 4..4+N-1: first_ts[s].
    - 4+N..4+2N-1: vld_cnt[s].
    - 4+2N..4+2N+C-1: cap_data[k].
    - 4+2N+C: cap_valid bits.
    - Any higher index reads 0.
- sticky_o is a direct register output with no extra latency relative to the flags.
- All counters are unsigned; values narrower than 32 bits are zero-extended on read.

Decomposition:
- Package gat_dbg_pkg holds:
  - readout index constants: IDX_ID, IDX_STICKY, IDX_CYCLE, IDX_TSV, IDX_TS_BASE;
  - functions idx_cnt_base(N) and idx_cap_base(N).
- One sub-module, dbg_stage_probe, instantiated NUM_STAGES times. Per stage it holds:
  - the sticky flags, first_ts, ts_valid and saturating vld_cnt;
  - inputs: clk, rst_n, clear_i, vld, rdy, cycle counter.
- The capture slots and readout mux live in the top module.

Test Plan:
1. Reset, then read index 0 → 0x00F40104; read index 1 → 0 after release; rd_data_o is 0 during reset.
2. Pulse stage_vld_i[2] at cycles 10, 15 and 16:
   - index 4+2 → 10 (counter value at cycle 10);
   - index 4+4+2 → 3;
   - index 1 → bit 6 set (vld_sticky[2], packed {vld,rdy} for N=4).
3. Slot 0: match=10, mode 0; slot 1: match=20, mode 1. Drive hits at addr 10 with data 0xA then 0xB, and at addr 20 with 0xC then 0xD:
   - index 12 → 0xB;
   - index 13 → 0xC;
   - index 14 → 0b11.
4. Assert clear_i on the same cycle as stage_vld_i[0]:
   - vld_sticky[0] = 1;
   - vld_cnt[0] = 1;
   - first_ts[0] = counter at that cycle;
   - all other stages read 0.
5. Saturation with CNT_W=4: hold stage_vld_i[1] high for 20 cycles → vld_cnt[1] = 15; cycle counter reads 15 thereafter.
6. Assert rst_n low mid-capture with cap_valid set → all indices read 0 except MON_ID; readout returns to the map one cycle after the first edge with rst_n high.
